// File: rtl/seq_uart_tx.sv
// UART 8N1 transmitter fed by the sequencer: small byte FIFO in front of a
// start/data/stop serializer, with registered back-pressure and drop flag.
module seq_uart_tx #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_busy,
    output logic              o_tx,
    output logic              o_idle,
    output logic              o_drop
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_nxt;
    logic [BIT_W-1:0]  bit_idx;
    logic [BIT_W-1:0]  bit_nxt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_nxt;
    logic              tx_nxt;

    logic              push;
    logic              pop;
    logic              baud_last;

    // o_busy is the registered full flag, so a push can never overflow
    assign push      = i_valid & ~o_busy;
    assign baud_last = (baud_cnt == BAUD_LAST);

    // Payload storage; written only on accept so X on an ignored i_data stays out
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Next-state, FIFO pop and line-level decode
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        pop       = 1'b0;
        count_nxt = count;
        tx_nxt    = 1'b1;

        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    baud_nxt  = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_nxt  = '0;
                    shift_nxt = shift >> 1;
                    if (bit_idx == BIT_LAST) begin
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_idx + BIT_W'(1);
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_nxt = '0;
                    // Chain straight into the next frame when data is waiting
                    if (count != '0) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        case ({push, pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase

        // Line level follows the state being entered so o_tx can be a flop
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    // State, pointers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            o_idle   <= 1'b1;
            o_drop   <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            count    <= count_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            o_tx   <= tx_nxt;
            o_busy <= (count_nxt == CNT_FULL);
            o_idle <= (count_nxt == '0) && (state_nxt == IDLE);
            o_drop <= i_valid & o_busy;
        end
    end

endmodule

// File: tb/tb_seq_uart_tx.sv
// Directed bench for seq_uart_tx at CLK_DIV=4: line-level frame checks, FIFO
// full/drop behaviour, back-to-back chaining, reset abort and a sender loop.
module tb_seq_uart_tx;

    localparam int unsigned CLK_DIV = 4;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] i_data  = 8'h00;
    logic       i_valid = 1'b0;
    logic       o_busy;
    logic       o_tx;
    logic       o_idle;
    logic       o_drop;

    int tests_run    = 0;
    int tests_failed = 0;
    int drop_cnt     = 0;
    int frame_err    = 0;

    logic [7:0] rx_q [$];
    logic [7:0] mon_b;
    bit         mon_abort;

    seq_uart_tx #(
        .CLK_DIV   (CLK_DIV),
        .DATA_W    (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_data (i_data),
        .i_valid(i_valid),
        .o_busy (o_busy),
        .o_tx   (o_tx),
        .o_idle (o_idle),
        .o_drop (o_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        if (!rst && o_drop === 1'b1) drop_cnt++;
    end

    // Receiver: start bit at offset 0, bit i sampled at 5+4i, stop at 37
    always begin
        @(posedge clk);
        #2;
        if (!rst && o_tx === 1'b0) begin
            mon_abort = 1'b0;
            mon_b     = 8'h00;
            for (int k = 1; k <= 37; k++) begin
                @(posedge clk);
                #2;
                if (rst) begin
                    mon_abort = 1'b1;
                    break;
                end
                if (k >= 5 && k <= 33 && (k % 4) == 1) mon_b[(k - 5) / 4] = o_tx;
            end
            if (!mon_abort) begin
                if (o_tx !== 1'b1) frame_err++;
                rx_q.push_back(mon_b);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int s);
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        return b[s - 1];
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        i_valid = 1'b0;
        step();
        step();
        tests_run++;
        if (o_tx !== 1'b1) begin tests_failed++; $display("FAIL reset o_tx: got %b want 1", o_tx); end
        tests_run++;
        if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset o_busy: got %b want 0", o_busy); end
        tests_run++;
        if (o_idle !== 1'b1) begin tests_failed++; $display("FAIL reset o_idle: got %b want 1", o_idle); end
        tests_run++;
        if (o_drop !== 1'b0) begin tests_failed++; $display("FAIL reset o_drop: got %b want 0", o_drop); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_frame;
        logic exp;
        rx_q.delete();
        i_data  = 8'h41;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        i_data  = 8'hxx;
        tests_run++;
        if (o_tx !== 1'b1) begin tests_failed++; $display("FAIL single_latency o_tx at N+1: got %b want 1", o_tx); end
        step();
        for (int i = 0; i < 40; i++) begin
            exp = frame_bit(8'h41, i / 4);
            tests_run++;
            if (o_tx !== exp) begin tests_failed++; $display("FAIL single_frame cycle %0d o_tx: got %b want %b", i, o_tx, exp); end
            step();
        end
        tests_run++;
        if (o_idle !== 1'b1) begin tests_failed++; $display("FAIL single_idle: got %b want 1", o_idle); end
        tests_run++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h41) begin
            tests_failed++;
            $display("FAIL single_rx: got %0d bytes first %h want 1 byte 41", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
        i_data = 8'h00;
    endtask

    task automatic test_burst;
        int   d0;
        logic exp;
        logic [7:0] b;
        rx_q.delete();
        d0 = drop_cnt;
        for (int c = 0; c <= 202; c++) begin
            i_valid = (c <= 5);
            i_data  = 8'(c + 1);
            if (c >= 2 && c <= 201) begin
                b   = 8'((c - 2) / 40 + 1);
                exp = frame_bit(b, ((c - 2) % 40) / 4);
                tests_run++;
                if (o_tx !== exp) begin tests_failed++; $display("FAIL burst_line cycle %0d o_tx: got %b want %b", c, o_tx, exp); end
            end
            if (c == 4 || c == 5 || c == 41 || c == 42) begin
                tests_run++;
                if (o_busy !== (c == 5 || c == 41)) begin
                    tests_failed++;
                    $display("FAIL burst_busy cycle %0d: got %b want %b", c, o_busy, (c == 5 || c == 41));
                end
            end
            if (c == 6 || c == 7) begin
                tests_run++;
                if (o_drop !== (c == 6)) begin tests_failed++; $display("FAIL burst_drop_pulse cycle %0d: got %b want %b", c, o_drop, (c == 6)); end
            end
            if (c == 201 || c == 202) begin
                tests_run++;
                if (o_idle !== (c == 202)) begin tests_failed++; $display("FAIL burst_idle cycle %0d: got %b want %b", c, o_idle, (c == 202)); end
            end
            step();
        end
        i_valid = 1'b0;
        tests_run++;
        if (drop_cnt - d0 != 1) begin tests_failed++; $display("FAIL burst_drop_count: got %0d want 1", drop_cnt - d0); end
        tests_run++;
        if (rx_q.size() != 5) begin tests_failed++; $display("FAIL burst_rx_size: got %0d want 5", rx_q.size()); end
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            tests_run++;
            if (rx_q[i] !== 8'(i + 1)) begin tests_failed++; $display("FAIL burst_rx[%0d]: got %h want %h", i, rx_q[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_pointer_wrap;
        int d0;
        int sent;
        int c;
        rx_q.delete();
        d0   = drop_cnt;
        sent = 0;
        c    = 0;
        while (sent < 10 && c < 1000) begin
            if (o_busy === 1'b0) begin
                i_valid = 1'b1;
                i_data  = 8'(8'hA0 + sent);
                sent++;
            end else begin
                i_valid = 1'b0;
            end
            step();
            c++;
        end
        i_valid = 1'b0;
        tests_run++;
        if (sent != 10) begin tests_failed++; $display("FAIL wrap_push_timeout: sent %0d want 10", sent); end
        c = 0;
        while (!(o_idle === 1'b1 && rx_q.size() >= 10) && c < 800) begin
            step();
            c++;
        end
        tests_run++;
        if (rx_q.size() != 10) begin tests_failed++; $display("FAIL wrap_rx_size: got %0d want 10", rx_q.size()); end
        for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
            tests_run++;
            if (rx_q[i] !== 8'(8'hA0 + i)) begin tests_failed++; $display("FAIL wrap_rx[%0d]: got %h want %h", i, rx_q[i], 8'(8'hA0 + i)); end
        end
        tests_run++;
        if (drop_cnt != d0) begin tests_failed++; $display("FAIL wrap_drop: got %0d drops want 0", drop_cnt - d0); end
    endtask

    task automatic test_push_pop_same_cycle;
        int d0;
        rx_q.delete();
        d0 = drop_cnt;
        for (int c = 0; c <= 122; c++) begin
            i_valid = (c == 0 || c == 5 || c == 41);
            i_data  = (c == 0) ? 8'h11 : (c == 5) ? 8'h22 : 8'h55;
            if (c == 41 || c == 81 || c == 82) begin
                tests_run++;
                if (o_tx !== (c != 82)) begin tests_failed++; $display("FAIL pushpop_line cycle %0d o_tx: got %b want %b", c, o_tx, (c != 82)); end
            end
            if (c == 121 || c == 122) begin
                tests_run++;
                if (o_idle !== (c == 122)) begin tests_failed++; $display("FAIL pushpop_idle cycle %0d: got %b want %b", c, o_idle, (c == 122)); end
            end
            step();
        end
        i_valid = 1'b0;
        tests_run++;
        if (rx_q.size() != 3 || rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22 || rx_q[2] !== 8'h55) begin
            tests_failed++;
            $display("FAIL pushpop_rx: got %0d bytes %p want 11 22 55", rx_q.size(), rx_q);
        end
        tests_run++;
        if (drop_cnt != d0) begin tests_failed++; $display("FAIL pushpop_drop: got %0d drops want 0", drop_cnt - d0); end
    endtask

    task automatic test_reset_mid_frame;
        int c;
        rx_q.delete();
        for (int k = 0; k <= 19; k++) begin
            i_valid = (k <= 2);
            i_data  = (k == 0) ? 8'h96 : (k == 1) ? 8'h33 : 8'h44;
            if (k == 19) begin
                tests_run++;
                if (o_tx !== 1'b0) begin tests_failed++; $display("FAIL rstmid_bit3 o_tx: got %b want 0", o_tx); end
                rst = 1'b1;
            end
            step();
        end
        i_valid = 1'b0;
        tests_run++;
        if (o_tx !== 1'b1) begin tests_failed++; $display("FAIL rstmid_tx_after: got %b want 1", o_tx); end
        tests_run++;
        if (o_idle !== 1'b1) begin tests_failed++; $display("FAIL rstmid_idle_after: got %b want 1", o_idle); end
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step();
            tests_run++;
            if (o_tx !== 1'b1 || o_idle !== 1'b1) begin
                tests_failed++;
                $display("FAIL rstmid_quiet cycle %0d: o_tx=%b o_idle=%b want 1 1", k, o_tx, o_idle);
            end
        end
        tests_run++;
        if (rx_q.size() != 0) begin tests_failed++; $display("FAIL rstmid_no_frames: got %0d bytes want 0", rx_q.size()); end
        i_data  = 8'h3C;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        c = 0;
        while (!(o_idle === 1'b1 && rx_q.size() >= 1) && c < 100) begin
            step();
            c++;
        end
        tests_run++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
            tests_failed++;
            $display("FAIL rstmid_resend: got %0d bytes first %h want 1 byte 3c", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back_sender;
        logic [7:0] exp_q [$];
        int d0;
        int w;
        int c;
        rx_q.delete();
        d0 = drop_cnt;
        for (int n = 0; n < 100; n++) begin
            repeat ($urandom_range(0, 3)) step();
            w = 0;
            while (o_busy === 1'b1 && w < 200) begin
                step();
                w++;
            end
            tests_run++;
            if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL sender_busy_timeout at send %0d: o_busy=%b want 0", n, o_busy); end
            i_data  = 8'($urandom);
            i_valid = 1'b1;
            exp_q.push_back(i_data);
            step();
            i_valid = 1'b0;
        end
        c = 0;
        while (!(o_idle === 1'b1 && rx_q.size() >= 100) && c < 5000) begin
            step();
            c++;
        end
        tests_run++;
        if (drop_cnt != d0) begin tests_failed++; $display("FAIL sender_drop: got %0d drops want 0", drop_cnt - d0); end
        tests_run++;
        if (rx_q.size() != 100) begin tests_failed++; $display("FAIL sender_rx_size: got %0d want 100", rx_q.size()); end
        for (int i = 0; i < 100 && i < rx_q.size(); i++) begin
            tests_run++;
            if (rx_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL sender_rx[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        tests_run++;
        if (frame_err != 0) begin tests_failed++; $display("FAIL stop_bits: %0d frames with a low stop bit, want 0", frame_err); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_burst();
        test_pointer_wrap();
        test_push_pop_same_cycle();
        test_reset_mid_frame();
        test_back_to_back_sender();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
